eth_rx_frame_ctrl: RTL and testbench

//  Frame-level controller behind the RMII byte receiver. It sequences the byte stream into frames,

---
 rtl/eth_rx_frame_ctrl_if.sv | 26 ++
 rtl/eth_rx_frame_ctrl.sv | 168 ++++++++++++++++
 tb/tb_eth_rx_frame_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_ctrl_if.sv
// Byte-stream, buffer-write and frame-handoff signals of the RX frame controller.
// slave is the controller side; master is the receiver/buffer/consumer side.
interface eth_rx_frame_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              crs_dv_i;
    logic              rx_er_i;
    logic              frame_ack_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [7:0]        wr_data_o;
    logic              frame_valid_o;
    logic [ADDR_W:0]   frame_len_o;

    modport slave (
        input  byte_i, byte_valid_i, crs_dv_i, rx_er_i, frame_ack_i,
        output wr_en_o, wr_addr_o, wr_data_o, frame_valid_o, frame_len_o
    );

    modport master (
        output byte_i, byte_valid_i, crs_dv_i, rx_er_i, frame_ack_i,
        input  wr_en_o, wr_addr_o, wr_data_o, frame_valid_o, frame_len_o
    );
endinterface

// File: rtl/eth_rx_frame_ctrl.sv
// Ethernet RX frame controller: sequences received bytes into frames, filters on
// destination MAC, checks length and CRC-32 residue, writes accepted bytes to a
// single-frame buffer and hands the frame to the consumer with valid/ack.
module eth_rx_frame_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eth_rx_frame_ctrl_if.slave   rx,
    input  logic [47:0]          mac_addr_i,
    input  logic                 promisc_i,
    output logic [15:0]          drop_cnt_o
);
    localparam logic [31:0]   CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [ADDR_W:0] MIN_L     = (ADDR_W+1)'(MIN_LEN);
    localparam logic [ADDR_W:0] MAX_L     = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0] LAST_DA   = (ADDR_W+1)'(5);

    typedef enum logic [2:0] {SYNC, IDLE, ADDR, DATA, DISCARD, HOLD} state_t;

    state_t          state;
    logic            crs_prev;
    logic [ADDR_W:0] len;
    logic [31:0]     crc;
    logic            own_ok;
    logic            bc_ok;
    logic            armed;

    logic            gap;
    logic            er;
    logic [2:0]      idx;
    logic [47:0]     mac_sh;
    logic [7:0]      mac_byte;
    logic            own_nxt;
    logic            bc_nxt;
    logic [31:0]     crc_upd;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // EOF-gap detect, destination byte compare and next CRC for the current byte
    always_comb begin
        gap      = !rx.crs_dv_i && !crs_prev;
        er       = rx.rx_er_i && rx.crs_dv_i;
        idx      = (state == IDLE) ? 3'd0 : len[2:0];
        mac_sh   = mac_addr_i << {idx, 3'b000};
        mac_byte = mac_sh[47:40];
        own_nxt  = ((state == IDLE) || own_ok) && (rx.byte_i == mac_byte);
        bc_nxt   = ((state == IDLE) || bc_ok) && (rx.byte_i == 8'hFF);
        crc_upd  = crc_step((state == IDLE) ? '1 : crc, rx.byte_i);
    end

    // Frame FSM with registered buffer-write, handoff and drop-counter outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= SYNC;
            crs_prev         <= 1'b1;
            len              <= '0;
            crc              <= '1;
            own_ok           <= 1'b0;
            bc_ok            <= 1'b0;
            armed            <= 1'b0;
            rx.wr_en_o       <= 1'b0;
            rx.wr_addr_o     <= '0;
            rx.wr_data_o     <= '0;
            rx.frame_valid_o <= 1'b0;
            rx.frame_len_o   <= '0;
            drop_cnt_o       <= '0;
        end else begin
            crs_prev   <= rx.crs_dv_i;
            rx.wr_en_o <= 1'b0;
            case (state)
                SYNC: begin
                    if (gap) state <= IDLE;
                end
                IDLE: begin
                    if (rx.byte_valid_i) begin
                        rx.wr_en_o   <= 1'b1;
                        rx.wr_addr_o <= '0;
                        rx.wr_data_o <= rx.byte_i;
                        len          <= (ADDR_W+1)'(1);
                        crc          <= crc_upd;
                        own_ok       <= own_nxt;
                        bc_ok        <= bc_nxt;
                        if (!promisc_i && !own_nxt && !bc_nxt) state <= DISCARD;
                        else                                   state <= ADDR;
                    end
                end
                ADDR: begin
                    if (er) begin
                        state <= DISCARD;
                    end else if (gap) begin
                        drop_cnt_o <= sat_inc(drop_cnt_o);
                        state      <= IDLE;
                    end else if (rx.byte_valid_i) begin
                        rx.wr_en_o   <= 1'b1;
                        rx.wr_addr_o <= len[ADDR_W-1:0];
                        rx.wr_data_o <= rx.byte_i;
                        len          <= len + 1'b1;
                        crc          <= crc_upd;
                        own_ok       <= own_nxt;
                        bc_ok        <= bc_nxt;
                        if (!promisc_i && !own_nxt && !bc_nxt) state <= DISCARD;
                        else if (len == LAST_DA)               state <= DATA;
                    end
                end
                DATA: begin
                    if (er) begin
                        state <= DISCARD;
                    end else if (gap) begin
                        if (len >= MIN_L && crc == CRC_RESIDUE) begin
                            rx.frame_valid_o <= 1'b1;
                            rx.frame_len_o   <= len;
                            armed            <= 1'b1;
                            state            <= HOLD;
                        end else begin
                            drop_cnt_o <= sat_inc(drop_cnt_o);
                            state      <= IDLE;
                        end
                    end else if (rx.byte_valid_i) begin
                        if (len == MAX_L) begin
                            state <= DISCARD;
                        end else begin
                            rx.wr_en_o   <= 1'b1;
                            rx.wr_addr_o <= len[ADDR_W-1:0];
                            rx.wr_data_o <= rx.byte_i;
                            len          <= len + 1'b1;
                            crc          <= crc_upd;
                        end
                    end
                end
                DISCARD: begin
                    if (gap) begin
                        drop_cnt_o <= sat_inc(drop_cnt_o);
                        state      <= IDLE;
                    end
                end
                HOLD: begin
                    // armed marks "an EOF gap has passed since the last overrun count",
                    // so a frame arriving while held is counted once, on its first byte
                    if (rx.frame_ack_i) begin
                        rx.frame_valid_o <= 1'b0;
                        state            <= SYNC;
                    end else if (rx.byte_valid_i && armed) begin
                        drop_cnt_o <= sat_inc(drop_cnt_o);
                        armed      <= 1'b0;
                    end else if (gap) begin
                        armed <= 1'b1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed testbench for eth_rx_frame_ctrl: good/bad CRC, address filter,
// length limits, overrun while held, rx_er abort and mid-frame reset.
module tb_eth_rx_frame_ctrl;
    localparam int ADDR_W = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] mac_addr;
    logic        promisc;
    logic [15:0] drop_cnt;

    eth_rx_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    eth_rx_frame_ctrl #(.ADDR_W(ADDR_W), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (bus.slave),
        .mac_addr_i (mac_addr),
        .promisc_i  (promisc),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] frm [0:1599];
    int n_cmp = 0;
    int n_bad = 0;
    int wr_total = 0;
    int addr_err = 0;
    int data_err = 0;
    int last_addr = -1;
    int exp_drop = 0;
    int w0;
    int a0;
    int d0;

    // write monitor: counts writes, checks address continuity and data vs sent frame
    always @(negedge clk) begin
        if (bus.wr_en_o === 1'b1) begin
            if (!(bus.wr_addr_o == '0 || int'(bus.wr_addr_o) == last_addr + 1)) addr_err++;
            if (bus.wr_data_o !== frm[bus.wr_addr_o]) data_err++;
            last_addr = int'(bus.wr_addr_o);
            wr_total++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // fill frm with dest, fixed source, patterned payload and a correct FCS
    task automatic build(input logic [47:0] dest, input int len, input logic [7:0] seed);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < 6; i++) frm[i] = dest[47-8*i -: 8];
        for (int i = 6; i < 12; i++) frm[i] = 8'(8'hA0 + i);
        for (int i = 12; i < len - 4; i++) frm[i] = 8'(i * 7) ^ seed;
        for (int i = 0; i < len - 4; i++) c = crc_byte(c, frm[i]);
        c = ~c;
        frm[len-4] = c[7:0];
        frm[len-3] = c[15:8];
        frm[len-2] = c[23:16];
        frm[len-1] = c[31:24];
    endtask

    task automatic send(input int len, input int rst_at, input int er_at);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("rst_wr_en", 32'(bus.wr_en_o), 0);
                check("rst_wr_addr", 32'(bus.wr_addr_o), 0);
                check("rst_wr_data", 32'(bus.wr_data_o), 0);
                check("rst_valid", 32'(bus.frame_valid_o), 0);
                check("rst_len", 32'(bus.frame_len_o), 0);
                check("rst_drop", 32'(drop_cnt), 0);
            end
            bus.crs_dv_i     = 1'b1;
            bus.byte_valid_i = 1'b1;
            bus.byte_i       = frm[i];
            bus.rx_er_i      = (i == er_at);
            rst_n            = !(i == rst_at);
        end
        @(posedge clk); #1;
        bus.crs_dv_i     = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.rx_er_i      = 1'b0;
        rst_n            = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic ack(input string tag);
        @(posedge clk); #1;
        bus.frame_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.frame_ack_i = 1'b0;
        check(tag, 32'(bus.frame_valid_o), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        w0 = wr_total;
        a0 = addr_err;
        d0 = data_err;
    endtask

    initial begin
        mac_addr         = 48'h02_00_00_00_00_01;
        promisc          = 1'b0;
        bus.byte_i       = '0;
        bus.byte_valid_i = 1'b0;
        bus.crs_dv_i     = 1'b0;
        bus.rx_er_i      = 1'b0;
        bus.frame_ack_i  = 1'b0;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr_en", 32'(bus.wr_en_o), 0);
        check("reset_wr_addr", 32'(bus.wr_addr_o), 0);
        check("reset_valid", 32'(bus.frame_valid_o), 0);
        check("reset_len", 32'(bus.frame_len_o), 0);
        check("reset_drop", 32'(drop_cnt), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: good 64-byte frame to own MAC
        build(mac_addr, 64, 8'h00);
        snap();
        send(64, -1, -1);
        check("t1_writes", 32'(wr_total - w0), 64);
        check("t1_last_addr", 32'(last_addr), 63);
        check("t1_addr_seq", 32'(addr_err - a0), 0);
        check("t1_data", 32'(data_err - d0), 0);
        check("t1_valid", 32'(bus.frame_valid_o), 1);
        check("t1_len", 32'(bus.frame_len_o), 64);
        check("t1_drop", 32'(drop_cnt), 0);
        ack("t1_ack");

        // 2: one payload bit flipped, FCS left unchanged
        build(mac_addr, 64, 8'h00);
        frm[30] = frm[30] ^ 8'h04;
        send(64, -1, -1);
        exp_drop++;
        check("t2_valid", 32'(bus.frame_valid_o), 0);
        check("t2_drop", 32'(drop_cnt), 32'(exp_drop));

        // 3: foreign destination, then promiscuous, then broadcast
        build(48'h02_00_00_00_00_99, 64, 8'h11);
        snap();
        send(64, -1, -1);
        exp_drop++;
        check("t3_filt_writes", 32'(wr_total - w0), 6);
        check("t3_filt_valid", 32'(bus.frame_valid_o), 0);
        check("t3_filt_drop", 32'(drop_cnt), 32'(exp_drop));
        promisc = 1'b1;
        send(64, -1, -1);
        check("t3_promisc_valid", 32'(bus.frame_valid_o), 1);
        check("t3_promisc_len", 32'(bus.frame_len_o), 64);
        ack("t3_promisc_ack");
        promisc = 1'b0;
        build(48'hFF_FF_FF_FF_FF_FF, 72, 8'h22);
        send(72, -1, -1);
        check("t3_bcast_valid", 32'(bus.frame_valid_o), 1);
        check("t3_bcast_len", 32'(bus.frame_len_o), 72);
        check("t3_bcast_drop", 32'(drop_cnt), 32'(exp_drop));
        ack("t3_bcast_ack");

        // 4: oversize frame, then undersize good-CRC frame
        build(mac_addr, 1600, 8'h33);
        snap();
        send(1600, -1, -1);
        exp_drop++;
        check("t4_big_writes", 32'(wr_total - w0), 1518);
        check("t4_big_last_addr", 32'(last_addr), 1517);
        check("t4_big_addr_seq", 32'(addr_err - a0), 0);
        check("t4_big_valid", 32'(bus.frame_valid_o), 0);
        check("t4_big_drop", 32'(drop_cnt), 32'(exp_drop));
        build(mac_addr, 60, 8'h44);
        send(60, -1, -1);
        exp_drop++;
        check("t4_small_valid", 32'(bus.frame_valid_o), 0);
        check("t4_small_drop", 32'(drop_cnt), 32'(exp_drop));

        // 5: overrun while held, ack, then next frame accepted
        build(mac_addr, 100, 8'h55);
        send(100, -1, -1);
        check("t5_held_valid", 32'(bus.frame_valid_o), 1);
        check("t5_held_len", 32'(bus.frame_len_o), 100);
        snap();
        send(100, -1, -1);
        exp_drop++;
        check("t5_ovr_writes", 32'(wr_total - w0), 0);
        check("t5_ovr_len", 32'(bus.frame_len_o), 100);
        check("t5_ovr_valid", 32'(bus.frame_valid_o), 1);
        check("t5_ovr_drop", 32'(drop_cnt), 32'(exp_drop));
        ack("t5_ack");
        build(mac_addr, 64, 8'h66);
        send(64, -1, -1);
        check("t5_third_valid", 32'(bus.frame_valid_o), 1);
        check("t5_third_len", 32'(bus.frame_len_o), 64);
        ack("t5_third_ack");

        // rx_er during data aborts the frame
        build(mac_addr, 64, 8'h77);
        send(64, -1, 30);
        exp_drop++;
        check("er_valid", 32'(bus.frame_valid_o), 0);
        check("er_drop", 32'(drop_cnt), 32'(exp_drop));

        // 6: reset at byte 20, remainder ignored, next frame accepted
        build(mac_addr, 64, 8'h88);
        snap();
        send(64, 20, -1);
        exp_drop = 0;
        check("t6_writes", 32'(wr_total - w0), 20);
        check("t6_drop", 32'(drop_cnt), 32'(exp_drop));
        check("t6_valid", 32'(bus.frame_valid_o), 0);
        build(mac_addr, 64, 8'h99);
        snap();
        send(64, -1, -1);
        check("t6_next_writes", 32'(wr_total - w0), 64);
        check("t6_next_data", 32'(data_err - d0), 0);
        check("t6_next_valid", 32'(bus.frame_valid_o), 1);
        check("t6_next_len", 32'(bus.frame_len_o), 64);
        check("t6_next_drop", 32'(drop_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
